sprite_pixel_fetch: RTL and testbench
=====================================

Name: sprite_pixel_fetch

Overview:
- Consumer stage for the on-chip sprite RAM (4-bit palette index per pixel, 20x40 sprite, 1-cycle synchronous read).
- Takes VGA scan coordinates and the sprite position, then generates the RAM read address.
- Absorbs the RAM read latency and converts the returned index to 24-bit RGB plus a hit/transparent flag for the colour mapper.
- Sprite position, frame select and flip are latched once per frame, so the sprite never tears mid-scan.

Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 40, sprite height in pixels
- NUM_FRAMES, 2, animation frames stored back-to-back in the RAM (frame f at base f*SPR_W*SPR_H)
- KEY_IDX, 4'hF, palette index treated as transparent (pink key)
- INIT_X, 10'd100, sprite X after reset
- INIT_Y, 10'd200, sprite Y after reset

Ports:
- CLK  in  1  pixel clock, shared with the sprite RAM
- Reset  in  1  synchronous, active-high
- DrawX  in  10  current scan X
- DrawY  in  10  current scan Y
- blank  in  1  1 = active video
- vsync  in  1  active-low vertical sync
- SpriteX  in  10  requested sprite top-left X
- SpriteY  in  10  requested sprite top-left Y
- frame_sel  in  1  requested animation frame
- flip_h  in  1  requested horizontal mirror
- READ_ADDR  out  19  address to sprite RAM
- data_out  in  4  palette index returned by sprite RAM
- sprite_hit  out  1  1 = opaque sprite pixel at the aligned position
- Red  out  8  sprite colour, valid when sprite_hit=1
- Green  out  8  sprite colour, valid when sprite_hit=1
- Blue  out  8  sprite colour, valid when sprite_hit=1

Behaviour:
- Reset:
  - READ_ADDR=0, sprite_hit=0, RGB=0.
  - Latched position = (INIT_X, INIT_Y); latched frame=0; latched flip=0.
  - Pipeline valid bits cleared.
  - Reset asserted mid-line clears everything on the next edge; no stale hit may emerge afterwards.
- Frame latch:
  - A falling edge of vsync (registered previous value 1, current 0) copies SpriteX, SpriteY, frame_sel and flip_h into the latch registers on that edge.
  - At all other times the latch holds.
  - A frame_sel value >= NUM_FRAMES is clamped to 0.
- Stage 0 (registered at edge k):
  - dx = DrawX - latX and dy = DrawY - latY, computed 11 bits wide and signed.
  - inbox = blank & dx in [0, SPR_W-1] & dy in [0, SPR_H-1]. No wrap: a sprite at X=630 clips at the screen edge and never reappears at X=0.
  - col = flip ? SPR_W-1-dx : dx.
  - READ_ADDR <= frame*SPR_W*SPR_H + dy*SPR_W + col when inbox, otherwise 0.
  - v1 <= inbox.
- Stage 1 (edge k+1):
  - The RAM registers data_out from READ_ADDR.
  - v2 <= v1.
- Stage 2 (edge k+2):
  - sprite_hit <= v2 & (data_out != KEY_IDX).
  - RGB <= PALETTE[data_out] when hit, otherwise 0.
- Latency: coordinates applied before edge k give outputs valid after edge k+2. Downstream delays DrawX/DrawY and its background path by 3 registers to match.
- Streaming: pipeline accepts one pixel per clock continuously, with no stalls.
- Simultaneous events: when the vsync edge coincides with an in-box pixel, that pixel uses the old latch values. vsync occurs in blanking, so no visible effect.
- Width rules:
  - Address math is 19-bit unsigned; maximum address = NUM_FRAMES*800-1 = 1599.
  - dy*SPR_W uses a constant multiply (shift-add permitted).

Decomposition:
- Package sprite_pkg:
  - SPR_W/SPR_H defaults
  - rgb_t struct (8/8/8)
  - 16-entry PALETTE constant array of rgb_t, with index 0 = black and 4'hF = pink key
- One sub-module, sprite_palette: combinational index -> rgb_t lookup. It is reused by other sprite stages.
- The pipeline and frame latch stay in the top module.

Test Plan:
1. Reset, then no vsync edge, DrawX=100, DrawY=200, blank=1 -> READ_ADDR=0 after edge 0. Stub RAM returns 4'h3 -> sprite_hit=1 and RGB=PALETTE[3] after edge 2.
2. Latched pos (100,200), DrawX=119, DrawY=239, frame 0, no flip -> READ_ADDR=799. DrawX=120 -> READ_ADDR=0 and sprite_hit=0 three cycles later.
3. frame_sel=1, flip_h=1, then vsync falling edge, then DrawX=100, DrawY=200 -> READ_ADDR=800+19=819. Changing SpriteX mid-frame has no effect until the next vsync edge.
4. Stub RAM returns KEY_IDX for an in-box pixel -> sprite_hit=0 and RGB=0. Same pixel with blank=0 -> READ_ADDR=0 and sprite_hit=0.
5. SpriteX=630 latched, scan X 630..639 -> hits at X 630..639. DrawX=0..9 on the same rows -> no hits (no wrap).
6. Continuous scan of one line with Reset asserted for 1 cycle mid-sprite -> sprite_hit=0 on the 3 outputs following reset. Latch returns to (100,200) and normal hits resume on the next in-box pixel.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite rendering stages.
//   SPR_W_DFLT / SPR_H_DFLT : default sprite geometry in pixels
//   ADDR_W                  : sprite RAM address width
//   rgb_t                   : 8/8/8 colour triple
//   PALETTE                 : 16-entry index -> colour table; 0 is black,
//                             4'hF is the pink transparency key colour
package sprite_pkg;

  localparam int SPR_W_DFLT = 20;
  localparam int SPR_H_DFLT = 40;
  localparam int ADDR_W     = 19;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t PALETTE [16] = '{
    '{8'h00, 8'h00, 8'h00},  // 0 black
    '{8'hFF, 8'hFF, 8'hFF},  // 1 white
    '{8'hFF, 8'h00, 8'h00},  // 2 red
    '{8'h00, 8'hFF, 8'h00},  // 3 green
    '{8'h00, 8'h00, 8'hFF},  // 4 blue
    '{8'hFF, 8'hFF, 8'h00},  // 5 yellow
    '{8'h00, 8'hFF, 8'hFF},  // 6 cyan
    '{8'h80, 8'h80, 8'h80},  // 7 grey
    '{8'hC0, 8'hC0, 8'hC0},  // 8 light grey
    '{8'h80, 8'h00, 8'h00},  // 9 maroon
    '{8'h00, 8'h80, 8'h00},  // A dark green
    '{8'h00, 8'h00, 8'h80},  // B navy
    '{8'hFF, 8'h80, 8'h00},  // C orange
    '{8'h80, 8'h40, 8'h00},  // D brown
    '{8'h40, 8'h40, 8'h40},  // E dark grey
    '{8'hFF, 8'h00, 8'hFF}   // F pink key
  };

endpackage

// File: rtl/sprite_palette.sv
// sprite_palette: combinational palette lookup shared by the sprite stages.
//   idx : 4-bit palette index
//   rgb : colour for that index (rgb_t)
module sprite_palette
  import sprite_pkg::*;
(
  input  logic [3:0] idx,
  output rgb_t       rgb
);

  assign rgb = PALETTE[idx];

endmodule

// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: turns the VGA scan position into sprite RAM reads and
// the returned palette index into an RGB colour plus an opaque-hit flag.
//   CLK, Reset           : pixel clock, synchronous active-high reset
//   DrawX, DrawY, blank  : scan position and active-video flag
//   vsync                : active-low vertical sync; its falling edge latches
//                          SpriteX/SpriteY/frame_sel/flip_h for the next frame
//   READ_ADDR / data_out : sprite RAM address out, palette index back (1-cycle)
//   sprite_hit, Red/Green/Blue : result, 3 clocks after the scan coordinate
module sprite_pixel_fetch
  import sprite_pkg::*;
#(
  parameter int         SPR_W      = SPR_W_DFLT,
  parameter int         SPR_H      = SPR_H_DFLT,
  parameter int         NUM_FRAMES = 2,
  parameter logic [3:0] KEY_IDX    = 4'hF,
  parameter logic [9:0] INIT_X     = 10'd100,
  parameter logic [9:0] INIT_Y     = 10'd200
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              vsync,
  input  logic [9:0]        SpriteX,
  input  logic [9:0]        SpriteY,
  input  logic              frame_sel,
  input  logic              flip_h,
  output logic [ADDR_W-1:0] READ_ADDR,
  input  logic [3:0]        data_out,
  output logic              sprite_hit,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue
);

  localparam logic signed [10:0] DX_MAX     = 11'(SPR_W - 1);
  localparam logic signed [10:0] DY_MAX     = 11'(SPR_H - 1);
  localparam logic [ADDR_W-1:0]  W_A        = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0]  COL_MAX_A  = ADDR_W'(SPR_W - 1);
  localparam logic [ADDR_W-1:0]  FRAME_SZ_A = ADDR_W'(SPR_W * SPR_H);
  localparam logic [31:0]        NF_U       = 32'(NUM_FRAMES);

  logic        vsync_q;
  logic [9:0]  lat_x;
  logic [9:0]  lat_y;
  logic        lat_frame;
  logic        lat_flip;
  logic        frame_ok;

  logic signed [10:0]  dx_c;
  logic signed [10:0]  dy_c;
  logic                inbox_c;
  logic [ADDR_W-1:0]   col_c;
  logic [ADDR_W-1:0]   row_c;
  logic [ADDR_W-1:0]   base_c;
  logic [ADDR_W-1:0]   addr_c;

  logic  vld_p0;
  logic  vld_p1;
  logic  hit_c;
  rgb_t  pal_rgb;
  rgb_t  rgb_p2;

  // Out-of-range frame requests fall back to frame 0.
  assign frame_ok = {31'd0, frame_sel} < NF_U;

  // Offsets are signed so pixels left of / above the sprite compare as
  // negative instead of wrapping into the box.
  assign dx_c    = $signed({1'b0, DrawX}) - $signed({1'b0, lat_x});
  assign dy_c    = $signed({1'b0, DrawY}) - $signed({1'b0, lat_y});
  assign inbox_c = blank && (dx_c >= 11'sd0) && (dx_c <= DX_MAX)
                         && (dy_c >= 11'sd0) && (dy_c <= DY_MAX);

  // Only used when inbox_c holds, so the low 10 bits are the true offset.
  assign col_c  = lat_flip ? (COL_MAX_A - {9'd0, dx_c[9:0]}) : {9'd0, dx_c[9:0]};
  assign row_c  = {9'd0, dy_c[9:0]} * W_A;
  assign base_c = {{(ADDR_W-1){1'b0}}, lat_frame} * FRAME_SZ_A;
  assign addr_c = base_c + row_c + col_c;

  assign hit_c = vld_p1 && (data_out != KEY_IDX);

  sprite_palette u_palette (
    .idx (data_out),
    .rgb (pal_rgb)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      vsync_q    <= 1'b1;
      lat_x      <= INIT_X;
      lat_y      <= INIT_Y;
      lat_frame  <= 1'b0;
      lat_flip   <= 1'b0;
      READ_ADDR  <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      sprite_hit <= 1'b0;
      rgb_p2     <= '0;
    end else begin
      vsync_q <= vsync;
      if (vsync_q && !vsync) begin
        lat_x     <= SpriteX;
        lat_y     <= SpriteY;
        lat_frame <= frame_ok ? frame_sel : 1'b0;
        lat_flip  <= flip_h;
      end
      // Stage 0: coordinate -> RAM address
      READ_ADDR <= inbox_c ? addr_c : '0;
      vld_p0    <= inbox_c;
      // Stage 1: RAM read in flight
      vld_p1    <= vld_p0;
      // Stage 2: index -> colour / hit
      sprite_hit <= hit_c;
      rgb_p2     <= hit_c ? pal_rgb : '0;
    end
  end

  assign Red   = rgb_p2.r;
  assign Green = rgb_p2.g;
  assign Blue  = rgb_p2.b;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
module tb_sprite_pixel_fetch;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank, vsync;
  logic [9:0]  SpriteX, SpriteY;
  logic        frame_sel, flip_h;
  logic [18:0] READ_ADDR;
  logic [3:0]  data_out;
  logic        sprite_hit;
  logic [7:0]  Red, Green, Blue;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] mem [0:1599];

  always #5 CLK = ~CLK;

  sprite_pixel_fetch dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .vsync      (vsync),
    .SpriteX    (SpriteX),
    .SpriteY    (SpriteY),
    .frame_sel  (frame_sel),
    .flip_h     (flip_h),
    .READ_ADDR  (READ_ADDR),
    .data_out   (data_out),
    .sprite_hit (sprite_hit),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue)
  );

  // Stub sprite RAM: one-cycle synchronous read.
  always @(posedge CLK) begin
    if (READ_ADDR < 19'd1600) data_out <= mem[READ_ADDR[10:0]];
    else                      data_out <= 4'h0;
  end

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        bl;
    logic [3:0]  ram;
    logic [18:0] addr;
    logic        hit;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [3:0] v);
    for (int i = 0; i < 1600; i++) mem[i] = v;
  endtask

  task automatic flush();
    blank = 1'b0;
    repeat (3) step();
  endtask

  task automatic vsync_pulse();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
  endtask

  function automatic logic [19:0] model_addr(input int x, input int y, input int lx,
                                             input int ly, input int lf, input int lfl,
                                             input logic bl);
    int dx, dy, col, a;
    logic ib;
    dx  = x - lx;
    dy  = y - ly;
    ib  = bl && dx >= 0 && dx < 20 && dy >= 0 && dy < 40;
    col = (lfl != 0) ? 19 - dx : dx;
    a   = ib ? lf * 800 + dy * 20 + col : 0;
    return {ib, 19'(a)};
  endfunction

  // Continuous scan of xs..xe on row y (RAM filled with an opaque index),
  // followed by two blank cycles to drain the pipeline. Reset is pulsed
  // for the cycle whose DrawX equals rst_x.
  task automatic scan(input int xs, input int xe, input int y, input int rst_x,
                      input int lx, input int ly, input int lf, input int lfl);
    logic h1, h2, exp_hit;
    logic [19:0] m;
    int n, x;
    h1 = 1'b0;
    h2 = 1'b0;
    n  = xe - xs + 1;
    for (int i = 0; i < n + 2; i++) begin
      x     = (i < n) ? xs + i : xe;
      DrawX = 10'(x);
      DrawY = 10'(y);
      blank = (i < n);
      Reset = (i < n) && (x == rst_x);
      step();
      if (Reset) begin
        m = 20'd0;
        exp_hit = 1'b0;
        h1 = 1'b0;
        h2 = 1'b0;
        lx = 100; ly = 200; lf = 0; lfl = 0;
      end else begin
        m = model_addr(x, y, lx, ly, lf, lfl, blank);
        exp_hit = h2;
        h2 = h1;
        h1 = m[19];
      end
      check($sformatf("scan_addr i=%0d x=%0d", i, x), {13'd0, READ_ADDR}, {13'd0, m[18:0]});
      check($sformatf("scan_hit i=%0d x=%0d", i, x), {31'd0, sprite_hit}, {31'd0, exp_hit});
    end
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; vsync = 1'b1; blank = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0;
    SpriteX = 10'd300; SpriteY = 10'd50; frame_sel = 1'b0; flip_h = 1'b0;
    fill_mem(4'h1);

    // Reset state
    step();
    step();
    check("reset_addr", {13'd0, READ_ADDR}, 32'd0);
    check("reset_hit", {31'd0, sprite_hit}, 32'd0);
    check("reset_rgb", {8'd0, Red, Green, Blue}, 32'd0);
    Reset = 1'b0;
    step();

    // Latch stays at (100,200), frame 0, no flip (no vsync edge seen).
    vecs[0] = '{10'd100, 10'd200, 1'b1, 4'h3, 19'd0,   1'b1, 24'h00FF00};
    vecs[1] = '{10'd119, 10'd239, 1'b1, 4'h5, 19'd799, 1'b1, 24'hFFFF00};
    vecs[2] = '{10'd120, 10'd239, 1'b1, 4'h3, 19'd0,   1'b0, 24'h000000};
    vecs[3] = '{10'd99,  10'd200, 1'b1, 4'h3, 19'd0,   1'b0, 24'h000000};
    vecs[4] = '{10'd110, 10'd210, 1'b1, 4'hF, 19'd210, 1'b0, 24'h000000};
    vecs[5] = '{10'd110, 10'd210, 1'b0, 4'h2, 19'd0,   1'b0, 24'h000000};
    vecs[6] = '{10'd105, 10'd220, 1'b1, 4'h7, 19'd405, 1'b1, 24'h808080};
    vecs[7] = '{10'd100, 10'd199, 1'b1, 4'h3, 19'd0,   1'b0, 24'h000000};
    vecs[8] = '{10'd100, 10'd240, 1'b1, 4'h3, 19'd0,   1'b0, 24'h000000};

    for (int i = 0; i < 9; i++) begin
      mem[vecs[i].addr[10:0]] = vecs[i].ram;
      DrawX = vecs[i].x;
      DrawY = vecs[i].y;
      blank = vecs[i].bl;
      step();
      check($sformatf("vec%0d_addr", i), {13'd0, READ_ADDR}, {13'd0, vecs[i].addr});
      blank = 1'b0;
      step();
      step();
      check($sformatf("vec%0d_hit", i), {31'd0, sprite_hit}, {31'd0, vecs[i].hit});
      check($sformatf("vec%0d_rgb", i), {8'd0, Red, Green, Blue}, {8'd0, vecs[i].rgb});
    end

    // Frame 1 + horizontal flip latched on a vsync falling edge.
    flush();
    fill_mem(4'h1);
    mem[819] = 4'h2;
    SpriteX = 10'd100; SpriteY = 10'd200; frame_sel = 1'b1; flip_h = 1'b1;
    vsync_pulse();
    DrawX = 10'd100; DrawY = 10'd200; blank = 1'b1;
    step();
    check("flip_addr_left", {13'd0, READ_ADDR}, 32'd819);
    SpriteX = 10'd300;  // must not take effect without a vsync edge
    DrawX = 10'd119;
    step();
    check("flip_addr_right", {13'd0, READ_ADDR}, 32'd800);
    DrawX = 10'd101; DrawY = 10'd201;
    step();
    check("midframe_hold_addr", {13'd0, READ_ADDR}, 32'd838);
    check("flip_hit", {31'd0, sprite_hit}, 32'd1);
    check("flip_rgb", {8'd0, Red, Green, Blue}, 32'h00FF0000);
    // vsync edge coinciding with an in-box pixel: that pixel uses old latch.
    SpriteX = 10'd50;
    vsync = 1'b0;
    DrawX = 10'd102;
    step();
    check("vsync_same_edge_addr", {13'd0, READ_ADDR}, 32'd837);
    vsync = 1'b1;
    DrawX = 10'd50; DrawY = 10'd200;
    step();
    check("new_latch_addr", {13'd0, READ_ADDR}, 32'd819);

    // Right-edge clip with no wrap to X=0.
    flush();
    fill_mem(4'h1);
    SpriteX = 10'd630; SpriteY = 10'd200; frame_sel = 1'b0; flip_h = 1'b0;
    vsync_pulse();
    flush();
    scan(625, 639, 205, -1, 630, 200, 0, 0);
    scan(0, 9, 205, -1, 630, 200, 0, 0);

    // Reset mid-sprite during a continuous line.
    flush();
    SpriteX = 10'd90; SpriteY = 10'd200; frame_sel = 1'b1; flip_h = 1'b1;
    vsync_pulse();
    flush();
    scan(85, 130, 205, 100, 90, 200, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
